// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default constants for the CPU sequencer slice.
//   state_t      : sequencer FSM states
//   *_DEF        : default timing parameters (phase count, gap length, memory phases)
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam int unsigned PHASES_DEF = 12;
  localparam int unsigned GAP_DEF    = 1;
  localparam int unsigned MEM_A_DEF  = 4;
  localparam int unsigned MEM_B_DEF  = 7;
  localparam int unsigned COUNT_W    = 16;

endpackage

// File: rtl/cpu_phase_timer.sv
// Phase/gap timer: walks one-hot phases with GAP idle cycles after each.
//   clk, reset  : clock, async active-low reset
//   advance     : at idle or boundary, start a new instruction at phase 0
//   stall       : memory not ready; holds phase MEM_A / MEM_B
//   phase       : registered one-hot phase strobes
//   boundary_c  : high in the last gap cycle after the final phase
module cpu_phase_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PHASES = PHASES_DEF,
  parameter int unsigned GAP    = GAP_DEF,
  parameter int unsigned MEM_A  = MEM_A_DEF,
  parameter int unsigned MEM_B  = MEM_B_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              stall,
  output logic [PHASES-1:0] phase,
  output logic              boundary_c
);

  localparam int unsigned IW = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IW-1:0] LAST  = IW'(PHASES - 1);
  localparam logic [IW-1:0] MA    = IW'(MEM_A);
  localparam logic [IW-1:0] MB    = IW'(MEM_B);
  localparam logic [GW-1:0] GLAST = GW'(GAP - 1);

  logic          busy, busy_n;
  logic          in_gap, in_gap_n;
  logic [IW-1:0] idx, idx_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [PHASES-1:0] phase_n;
  logic stretch_c, phase_end_c, gap_end_c, slot_end_c;

  // Slot decode: a slot is one phase cycle (possibly stretched) plus its gap.
  always_comb begin
    stretch_c   = busy && !in_gap && ((idx == MA) || (idx == MB)) && stall;
    phase_end_c = busy && !in_gap && !stretch_c;
    gap_end_c   = busy && in_gap && (gcnt == GLAST);
    slot_end_c  = (GAP == 0) ? phase_end_c : gap_end_c;
    boundary_c  = slot_end_c && (idx == LAST);
  end

  // Next-state for phase index, gap counter and one-hot strobe.
  always_comb begin
    busy_n   = busy;
    in_gap_n = in_gap;
    idx_n    = idx;
    gcnt_n   = gcnt;
    if (!busy || boundary_c) begin
      busy_n   = advance;
      idx_n    = '0;
      in_gap_n = 1'b0;
      gcnt_n   = '0;
    end else if (slot_end_c) begin
      idx_n    = idx + 1'b1;
      in_gap_n = 1'b0;
      gcnt_n   = '0;
    end else if (phase_end_c) begin
      in_gap_n = 1'b1;
      gcnt_n   = '0;
    end else if (in_gap) begin
      gcnt_n   = gcnt + 1'b1;
    end
    phase_n = (busy_n && !in_gap_n) ? (PHASES'(1) << idx_n) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy   <= 1'b0;
      in_gap <= 1'b0;
      idx    <= '0;
      gcnt   <= '0;
      phase  <= '0;
    end else begin
      busy   <= busy_n;
      in_gap <= in_gap_n;
      idx    <= idx_n;
      gcnt   <= gcnt_n;
      phase  <= phase_n;
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// CPU sequencer: IDLE/RUN/STEP/HALT control over the phase timer plus
// a completed-instruction counter.
//   clk, reset          : clock, async active-low reset
//   start, halt_req,
//   step_req            : single-cycle control requests
//   halt_instr          : decoder halt flag, honoured during the last phase
//   mem_wait            : stretches the memory phases
//   phase, instr_done   : one-hot strobes, last-phase marker
//   running, halted     : status
//   instr_count         : completed instructions (wraps)
module cpu_seq_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PHASES = PHASES_DEF,
  parameter int unsigned GAP    = GAP_DEF,
  parameter int unsigned MEM_A  = MEM_A_DEF,
  parameter int unsigned MEM_B  = MEM_B_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt_req,
  input  logic               step_req,
  input  logic               halt_instr,
  input  logic               mem_wait,
  output logic [PHASES-1:0]  phase,
  output logic               instr_done,
  output logic               running,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  state_t state, state_n;
  logic   halt_pend, instr_halt;
  logic   advance_c, boundary_c, last_c, stop_c;
  logic [COUNT_W-1:0] count_q;

  cpu_phase_timer #(
    .PHASES(PHASES),
    .GAP   (GAP),
    .MEM_A (MEM_A),
    .MEM_B (MEM_B)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .advance   (advance_c),
    .stall     (mem_wait),
    .phase     (phase),
    .boundary_c(boundary_c)
  );

  assign last_c      = phase[PHASES-1];
  assign instr_done  = last_c;
  assign instr_count = count_q;

  // Halt reasons include same-cycle requests so a late halt still wins.
  assign stop_c = halt_pend || halt_req || instr_halt || (last_c && halt_instr);

  // Next state and timer launch; start has priority over step_req in HALT.
  always_comb begin
    state_n   = state;
    advance_c = 1'b0;
    unique case (state)
      ST_IDLE: if (start) begin
        state_n   = ST_RUN;
        advance_c = 1'b1;
      end
      ST_HALT: if (start) begin
        state_n   = ST_RUN;
        advance_c = 1'b1;
      end else if (step_req) begin
        state_n   = ST_STEP;
        advance_c = 1'b1;
      end
      ST_RUN: if (boundary_c) begin
        if (stop_c) state_n = ST_HALT;
        else        advance_c = 1'b1;
      end
      ST_STEP: if (boundary_c) state_n = ST_HALT;
      default: state_n = ST_IDLE;
    endcase
  end

  // State, status outputs, halt flags and instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      running    <= 1'b0;
      halted     <= 1'b0;
      halt_pend  <= 1'b0;
      instr_halt <= 1'b0;
      count_q    <= '0;
    end else begin
      state   <= state_n;
      running <= (state_n == ST_RUN) || (state_n == ST_STEP);
      halted  <= (state_n == ST_HALT);
      if ((state_n == ST_HALT) && (state != ST_HALT)) halt_pend <= 1'b0;
      else                                             halt_pend <= halt_pend | halt_req;
      if (boundary_c) instr_halt <= 1'b0;
      else if ((state == ST_RUN) && last_c && halt_instr) instr_halt <= 1'b1;
      if (last_c) count_q <= count_q + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: stimulus pushes expected phase[0]
// cycles and instr_done (cycle, count) records; a monitor pops on each event.
module tb_cpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, halt_req, step_req, halt_instr, mem_wait;
  logic [11:0] phase;
  logic        instr_done, running, halted;
  logic [15:0] instr_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          c;
    logic [15:0] n;
  } done_t;

  int    q_p0[$];
  done_t q_done[$];

  cpu_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .halt_instr (halt_instr),
    .mem_wait   (mem_wait),
    .phase      (phase),
    .instr_done (instr_done),
    .running    (running),
    .halted     (halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents phase[0] or instr_done.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("phase_onehot", 32'($onehot0(phase)), 32'd1);
      if (phase[0]) begin
        if (q_p0.size() == 0) chk("unexpected_phase0", 32'(cyc), 32'hFFFF_FFFF);
        else                  chk("phase0_cycle", 32'(cyc), 32'(q_p0.pop_front()));
      end
      if (instr_done) begin
        if (q_done.size() == 0) chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
        else begin
          done_t e;
          e = q_done.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.c));
          chk("done_count", 32'(instr_count), 32'(e.n));
        end
      end
    end
  end

  initial begin
    int s, h, g, k, w;
    reset = 1'b1;
    start = 1'b0; halt_req = 1'b0; step_req = 1'b0; halt_instr = 1'b0; mem_wait = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_done", 32'(instr_done), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Free run: first instruction, then a stretched one, then halt_req.
    s = cyc + 5;
    goto(s - 1);
    chk("idle_phase", 32'(phase), 32'd0);
    q_p0.push_back(s + 1);
    q_done.push_back('{s + 23, 16'd0});
    q_p0.push_back(s + 25);
    q_done.push_back('{s + 50, 16'd1});
    q_p0.push_back(s + 52);
    q_done.push_back('{s + 74, 16'd2});
    goto(s); start = 1'b1;
    goto(s + 1); start = 1'b0;
    chk("run_running", 32'(running), 32'd1);
    goto(s + 26);
    chk("count_after_1", 32'(instr_count), 32'd1);

    goto(s + 33); mem_wait = 1'b1;
    chk("stall_p4_first", 32'(phase), 32'h010);
    goto(s + 36); mem_wait = 1'b0;
    chk("stall_p4_last", 32'(phase), 32'h010);
    goto(s + 37);
    chk("stall_gap", 32'(phase), 32'd0);

    goto(s + 58); halt_req = 1'b1;
    chk("halt_req_p3", 32'(phase), 32'h008);
    goto(s + 59); halt_req = 1'b0;
    goto(s + 76);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_running", 32'(running), 32'd0);
    goto(s + 78);
    chk("halt_phase", 32'(phase), 32'd0);
    chk("halt_count", 32'(instr_count), 32'd3);

    // Single step from HALT.
    h = s + 80;
    q_p0.push_back(h + 1);
    q_done.push_back('{h + 23, 16'd3});
    goto(h); step_req = 1'b1;
    goto(h + 1); step_req = 1'b0;
    chk("step_running", 32'(running), 32'd1);
    chk("step_halted", 32'(halted), 32'd0);
    goto(h + 25);
    chk("step_rehalted", 32'(halted), 32'd1);
    chk("step_count", 32'(instr_count), 32'd4);

    // Decoder halt in RUN.
    g = h + 28;
    q_p0.push_back(g + 1);
    q_done.push_back('{g + 23, 16'd4});
    goto(g); start = 1'b1;
    goto(g + 1); start = 1'b0;
    goto(g + 23); halt_instr = 1'b1;
    chk("hi_done", 32'(instr_done), 32'd1);
    goto(g + 24); halt_instr = 1'b0;
    goto(g + 25);
    chk("hi_halted", 32'(halted), 32'd1);
    chk("hi_count", 32'(instr_count), 32'd5);

    // start + step_req together goes to RUN; then reset during phase[6].
    k = g + 28;
    q_p0.push_back(k + 1);
    q_done.push_back('{k + 23, 16'd5});
    q_p0.push_back(k + 25);
    goto(k); start = 1'b1; step_req = 1'b1;
    goto(k + 1); start = 1'b0; step_req = 1'b0;
    goto(k + 30);
    chk("both_running", 32'(running), 32'd1);
    chk("both_halted", 32'(halted), 32'd0);
    goto(k + 37);
    chk("pre_rst_p6", 32'(phase), 32'h040);
    #2 reset = 1'b0;
    #1;
    chk("arst_phase", 32'(phase), 32'd0);
    chk("arst_done", 32'(instr_done), 32'd0);
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    chk("arst_count", 32'(instr_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    goto(cyc + 4);
    chk("post_rst_phase", 32'(phase), 32'd0);
    chk("post_rst_running", 32'(running), 32'd0);
    chk("post_rst_halted", 32'(halted), 32'd0);

    // Counter wrap from 0xFFFF.
    w = cyc + 2;
    q_p0.push_back(w + 1);
    q_done.push_back('{w + 23, 16'hFFFF});
    goto(w); start = 1'b1;
    goto(w + 1); start = 1'b0;
    force dut.count_q = 16'hFFFF;
    goto(w + 5); halt_req = 1'b1;
    goto(w + 6); halt_req = 1'b0;
    goto(w + 23);
    release dut.count_q;
    goto(w + 24);
    chk("wrap_count", 32'(instr_count), 32'd0);
    goto(w + 26);
    chk("wrap_halted", 32'(halted), 32'd1);
    goto(w + 30);
    chk("end_phase", 32'(phase), 32'd0);
    chk("left_p0", 32'(q_p0.size()), 32'd0);
    chk("left_done", 32'(q_done.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001 Parameter: PHASES, default 12, number of one-hot instruction phases per instruction.
REQ-002 Parameter: GAP, default 1, idle cycles (all phases low) after each phase.
REQ-003 Parameter: MEM_A, default 4, phase index that may be stretched by mem_wait.
REQ-004 Parameter: MEM_B, default 7, second phase index that may be stretched by mem_wait.
REQ-005 Port: clk  in  1  sole clock, all logic on rising edge.
REQ-006 Port: reset  in  1  asynchronous, active-low reset: reset=0 resets immediately; reset=1 is normal operation.
REQ-007 Port: start  in  1  single-cycle request to enter free-run.
REQ-008 Port: halt_req  in  1  single-cycle request to stop at the next instruction boundary.
REQ-009 Port: step_req  in  1  single-cycle request to execute exactly one instruction from HALT.
REQ-010 Port: halt_instr  in  1  decoder flag, sampled only while phase[PHASES-1] is high.
REQ-011 Port: mem_wait  in  1  memory not ready; stretches phase MEM_A or MEM_B.
REQ-012 Port: phase  out  PHASES  one-hot phase strobes, at most one bit high per cycle.
REQ-013 Port: instr_done  out  1  high in the cycle phase[PHASES-1] is high.
REQ-014 Port: running  out  1  high in states RUN and STEP.
REQ-015 Port: halted  out  1  high in state HALT.
REQ-016 Port: instr_count  out  16  count of completed instructions.

Function
REQ-017 The FSM shall have states IDLE, RUN, STEP and HALT.
REQ-018 Transitions: IDLE->RUN on start; HALT->RUN on start; HALT->STEP on step_req; start shall win over a simultaneous step_req.
REQ-019 In IDLE and HALT, phase shall be all-zero and start/step_req shall be the only inputs acted on.
REQ-020 If start is sampled high in cycle n, phase[0] shall be high in cycle n+1.
REQ-021 Phase k shall be high for one cycle, then GAP all-zero cycles, then phase k+1 high.
REQ-022 Unstalled instruction period shall be PHASES*(GAP+1) cycles (24 at defaults).
REQ-023 While phase[MEM_A] or phase[MEM_B] is high and mem_wait=1, that phase bit shall stay high.
REQ-024 The stretched phase shall advance to its gap on the first cycle in which mem_wait=0 is sampled; mem_wait shall be ignored in all other phases.
REQ-025 An instruction boundary is the last gap cycle after phase[PHASES-1].
REQ-026 halt_req shall be latched into a pending flag from any state, and cleared on entry to HALT.
REQ-027 In RUN, if halt_req is pending, or halt_instr=1 with phase[PHASES-1], the FSM shall enter HALT at the boundary with no further phase[0].
REQ-028 In RUN with no pending halt, phase[0] shall follow the boundary cycle immediately.
REQ-029 STEP shall run exactly one full instruction, then return to HALT at the boundary.
REQ-030 A start and a halt_req sampled in the same cycle in RUN: halt shall win.
REQ-031 instr_count shall increment in the cycle after instr_done and wrap from 0xFFFF to 0x0000.

Reset
REQ-032 On reset=0, outputs shall be immediately: state IDLE, phase=0, instr_done=0, running=0, halted=0, instr_count=0, halt pending cleared.
REQ-033 Reset asserted mid-instruction shall abort it with no completion pulse.
REQ-034 Release of reset shall produce no phase activity until start is sampled.

Structure
REQ-035 Package cpu_ctrl_pkg shall hold the state enumeration and the PHASES/GAP default constants.
REQ-036 Phase and gap timing shall live in one sub-module, cpu_phase_timer (inputs advance/stall, outputs one-hot phase and boundary strobe); cpu_seq_ctrl shall hold the FSM and counter.

Verification
REQ-037 Reset, start pulse at cycle 5 -> phase[0] at cycle 6, phase[11] and instr_done at cycle 28, phase[0] again at cycle 30.
REQ-038 mem_wait=1 for 3 cycles starting when phase[4] rises -> phase[4] high 4 cycles, instruction period 27.
REQ-039 halt_req during phase[3] -> instruction completes, halted=1 after boundary, no phase[0]; a later step_req -> exactly one instruction, instr_count +1, halted again.
REQ-040 halt_instr=1 during phase[11] in RUN -> HALT at boundary; start and step_req together in HALT -> RUN.
REQ-041 Preload 0xFFFF completions -> next instr_done wraps instr_count to 0x0000.
REQ-042 reset=0 during phase[6] -> all outputs zero asynchronously, no instr_done, IDLE after release.
